// File: rtl/wb2axi_pkg.sv
// Shared types and constants for the Wishbone-classic to AXI4-Lite bridge.
package wb2axi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // SLVERR and DECERR become a Wishbone error; OKAY and EXOKAY become an ack.
   function automatic logic resp_is_err(input logic [1:0] resp);
      resp_is_err = 1'b0;
      case (resp)
         RESP_SLVERR, RESP_DECERR: resp_is_err = 1'b1;
         RESP_OKAY, RESP_EXOKAY:   resp_is_err = 1'b0;
         default:                  resp_is_err = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/wishbone_to_axi4lite_watchdog.sv
// Transfer watchdog for the bridge: counts cycles spent outside IDLE and
// flags expiry once TIMEOUT_CYCLES have elapsed. Only built when
// WB2AXI_TIMEOUT_EN is defined.
module wb2axi_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic ACLK,
   input  logic ARESETN,
   input  logic busy,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   // Expiry is seen during the TIMEOUT_CYCLES-th busy cycle so the FSM is
   // back in IDLE right after that cycle.
   assign expired = busy && (count == CW'(TIMEOUT_CYCLES - 1));

   // Clear while idle, count every busy cycle, hold once expired.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)      count <= '0;
      else if (!busy)    count <= '0;
      else if (!expired) count <= count + CW'(1);
   end

endmodule

// File: rtl/wishbone_to_axi4lite.sv
// Wishbone classic slave to AXI4-Lite master bridge, one transfer in flight.
// The Wishbone request is latched, the AXI handshakes run, and a registered
// one-cycle ack or err returns. Optional watchdog: define WB2AXI_TIMEOUT_EN.
module wishbone_to_axi4lite
   import wb2axi_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   // Wishbone slave
   input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
   input  logic                    wb_we_i,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic                    wb_ack_o,
   output logic                    wb_err_o,
   // AXI4-Lite master
   output logic [ADDR_WIDTH-1:0]   AWADDR,
   output logic [2:0]              AWPROT,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   output logic [DATA_WIDTH-1:0]   WDATA,
   output logic [DATA_WIDTH/8-1:0] WSTRB,
   output logic                    WVALID,
   input  logic                    WREADY,
   input  logic [1:0]              BRESP,
   input  logic                    BVALID,
   output logic                    BREADY,
   output logic [ADDR_WIDTH-1:0]   ARADDR,
   output logic [2:0]              ARPROT,
   output logic                    ARVALID,
   input  logic                    ARREADY,
   input  logic [DATA_WIDTH-1:0]   RDATA,
   input  logic [1:0]              RRESP,
   input  logic                    RVALID,
   output logic                    RREADY
);

   state_t state, state_d;
   logic   aw_done, aw_done_d, w_done, w_done_d;
   logic   dropped, dropped_d;
   logic   awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d;
   logic   ack_d, err_d;
   logic   capture, load_rdata;
   logic   report, busy, timeout;

   assign AWPROT = 3'b000;
   assign ARPROT = 3'b000;

   // The initiator only hears about a transfer it never abandoned.
   assign report = wb_cyc_i && !dropped;
   assign busy   = (state != IDLE);

`ifdef WB2AXI_TIMEOUT_EN
   wb2axi_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .busy    (busy),
      .expired (timeout)
   );
`else
   logic [31:0] unused_timeout_cycles;
   assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
   assign timeout = 1'b0;
`endif

   // Next-state and next-output decode for the transfer FSM.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d    = state;
      awvalid_d  = AWVALID;
      wvalid_d   = WVALID;
      arvalid_d  = ARVALID;
      bready_d   = BREADY;
      rready_d   = RREADY;
      aw_done_d  = aw_done;
      w_done_d   = w_done;
      dropped_d  = dropped | (busy & ~wb_cyc_i);
      ack_d      = 1'b0;
      err_d      = 1'b0;
      capture    = 1'b0;
      load_rdata = 1'b0;

      case (state)
         IDLE: begin
            // While ack/err is showing, the initiator still holds the old
            // request; it is only taken as new one cycle later.
            if (wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o) begin
               capture   = 1'b1;
               dropped_d = 1'b0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               if (wb_we_i) begin
                  state_d   = WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = RD_REQ;
                  arvalid_d = 1'b1;
               end
            end
         end
         WR_REQ: begin
            if (AWVALID && AWREADY) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (WVALID && WREADY) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if (aw_done_d && w_done_d) begin
               state_d  = WR_RESP;
               bready_d = 1'b1;
            end
         end
         WR_RESP: begin
            if (BVALID) begin
               state_d  = IDLE;
               bready_d = 1'b0;
               ack_d    = report & ~resp_is_err(BRESP);
               err_d    = report &  resp_is_err(BRESP);
            end
         end
         RD_REQ: begin
            if (ARREADY) begin
               state_d   = RD_RESP;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         RD_RESP: begin
            if (RVALID) begin
               state_d    = IDLE;
               rready_d   = 1'b0;
               load_rdata = 1'b1;
               ack_d      = report & ~resp_is_err(RRESP);
               err_d      = report &  resp_is_err(RRESP);
            end
         end
         default: state_d = IDLE;
      endcase

      // Watchdog recovery abandons the AXI side and reports an error.
      if (timeout) begin
         state_d   = IDLE;
         awvalid_d = 1'b0;
         wvalid_d  = 1'b0;
         arvalid_d = 1'b0;
         bready_d  = 1'b0;
         rready_d  = 1'b0;
         ack_d     = 1'b0;
         err_d     = report;
      end
   end

   // State, handshake outputs and latched request/response registers.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state    <= IDLE;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         dropped  <= 1'b0;
         AWVALID  <= 1'b0;
         WVALID   <= 1'b0;
         ARVALID  <= 1'b0;
         BREADY   <= 1'b0;
         RREADY   <= 1'b0;
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= '0;
         AWADDR   <= '0;
         ARADDR   <= '0;
         WDATA    <= '0;
         WSTRB    <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register reading the
         // pre-edge values, matching the flops this describes.
         state    <= state_d;
         aw_done  <= aw_done_d;
         w_done   <= w_done_d;
         dropped  <= dropped_d;
         AWVALID  <= awvalid_d;
         WVALID   <= wvalid_d;
         ARVALID  <= arvalid_d;
         BREADY   <= bready_d;
         RREADY   <= rready_d;
         wb_ack_o <= ack_d;
         wb_err_o <= err_d;
         if (capture) begin
            if (wb_we_i) begin
               AWADDR <= wb_adr_i;
               WDATA  <= wb_dat_i;
               WSTRB  <= wb_sel_i;
            end else begin
               ARADDR <= wb_adr_i;
            end
         end
         if (load_rdata) wb_dat_o <= RDATA;
      end
   end

endmodule

// File: tb/tb_wishbone_to_axi4lite.sv
// Bench for wishbone_to_axi4lite: directed Wishbone requests against a
// scripted AXI4-Lite slave; a monitor pops expected responses from a queue.
module tb_wishbone_to_axi4lite;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
   logic [3:0]  wb_sel_i = '0;
   logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o, wb_err_o;
   logic [31:0] AWADDR, WDATA, ARADDR;
   logic [31:0] RDATA = '0;
   logic [3:0]  WSTRB;
   logic [2:0]  AWPROT, ARPROT;
   logic        AWVALID, WVALID, ARVALID, BREADY, RREADY;
   logic        AWREADY = 1'b0, WREADY = 1'b0, ARREADY = 1'b0;
   logic        BVALID = 1'b0, RVALID = 1'b0;
   logic [1:0]  BRESP = 2'b00, RRESP = 2'b00;

   always #5 ACLK = ~ACLK;

   wishbone_to_axi4lite #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
      .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
      .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          err;
      logic [31:0] dat;
      bit          chk;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   // Monitor: every ack/err must match the oldest expectation.
   initial forever begin
      @(negedge ACLK);
      if (ARESETN && (wb_ack_o || wb_err_o)) begin
         check("ack_err_excl", 32'(wb_ack_o & wb_err_o), 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_resp", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("resp_is_err", 32'(wb_err_o), 32'(mon_e.err));
            if (mon_e.chk) check("rdata", wb_dat_o, mon_e.dat);
         end
      end
   end

   task automatic wb_idle();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
   endtask

   // Issue one request (called just after a rising edge) and wait for ack/err.
   task automatic wb_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input bit exp_err, input logic [31:0] exp_dat,
                         input bit chk_dat, input int exp_lat);
      exp_t e;
      int   n;
      e.err = exp_err; e.dat = exp_dat; e.chk = chk_dat;
      exp_q.push_back(e);
      wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      n = 0;
      do begin
         @(posedge ACLK); n++;
         @(negedge ACLK);
      end while (!(wb_ack_o || wb_err_o) && n < 200);
      if (!(wb_ack_o || wb_err_o)) check("wb_resp_timeout", 32'(wb_ack_o | wb_err_o), 32'd1);
      else if (exp_lat >= 0) check("wb_latency", 32'(n), 32'(exp_lat));
      @(posedge ACLK); #1;
   endtask

   // Scripted write slave: independent AW/W waits, then B after b_wait cycles.
   task automatic slave_wr(input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] es,
                           input int aw_wait, input int w_wait, input int b_wait,
                           input logic [1:0] bresp);
      int n;
      fork
         begin
            int k = 0;
            @(negedge ACLK);
            while (!AWVALID && k < 200) begin @(negedge ACLK); k++; end
            if (!AWVALID) check("aw_timeout", 32'(AWVALID), 32'd1);
            else begin
               repeat (aw_wait) begin @(negedge ACLK); check("awvalid_held", 32'(AWVALID), 32'd1); end
               check("awaddr", AWADDR, ea);
               AWREADY = 1'b1;
               @(posedge ACLK); #1 AWREADY = 1'b0;
               @(negedge ACLK); check("awvalid_drop", 32'(AWVALID), 32'd0);
            end
         end
         begin
            int k = 0;
            @(negedge ACLK);
            while (!WVALID && k < 200) begin @(negedge ACLK); k++; end
            if (!WVALID) check("w_timeout", 32'(WVALID), 32'd1);
            else begin
               repeat (w_wait) begin @(negedge ACLK); check("wvalid_held", 32'(WVALID), 32'd1); end
               check("wdata", WDATA, ed);
               check("wstrb", 32'(WSTRB), 32'(es));
               WREADY = 1'b1;
               @(posedge ACLK); #1 WREADY = 1'b0;
               @(negedge ACLK); check("wvalid_drop", 32'(WVALID), 32'd0);
            end
         end
      join
      repeat (b_wait) @(negedge ACLK);
      BVALID = 1'b1; BRESP = bresp;
      n = 0;
      while (!BREADY && n < 200) begin @(negedge ACLK); n++; end
      if (!BREADY) check("bready_timeout", 32'(BREADY), 32'd1);
      @(posedge ACLK); #1 BVALID = 1'b0; BRESP = 2'b00;
      @(negedge ACLK); check("bready_drop", 32'(BREADY), 32'd0);
   endtask

   // Scripted read slave: AR accepted after ar_wait, R given r_wait later.
   task automatic slave_rd(input logic [31:0] ea, input int ar_wait, input int r_wait,
                           input logic [31:0] rdata, input logic [1:0] rresp);
      int n = 0;
      @(negedge ACLK);
      while (!ARVALID && n < 200) begin @(negedge ACLK); n++; end
      if (!ARVALID) check("ar_timeout", 32'(ARVALID), 32'd1);
      else begin
         repeat (ar_wait) begin @(negedge ACLK); check("arvalid_held", 32'(ARVALID), 32'd1); end
         check("araddr", ARADDR, ea);
         ARREADY = 1'b1;
         @(posedge ACLK); #1 ARREADY = 1'b0;
         @(negedge ACLK); check("arvalid_drop", 32'(ARVALID), 32'd0);
         repeat (r_wait) @(negedge ACLK);
         RVALID = 1'b1; RDATA = rdata; RRESP = rresp;
         n = 0;
         while (!RREADY && n < 200) begin @(negedge ACLK); n++; end
         if (!RREADY) check("rready_timeout", 32'(RREADY), 32'd1);
         @(posedge ACLK); #1 RVALID = 1'b0; RRESP = 2'b00;
         @(negedge ACLK); check("rready_drop", 32'(RREADY), 32'd0);
      end
   endtask

   function automatic logic [31:0] ctrl_bits();
      return {25'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY, wb_ack_o, wb_err_o};
   endfunction

   initial begin
      int n;
      // Reset state, both during and right after reset.
      repeat (2) @(negedge ACLK);
      check("rst_ctrl", ctrl_bits(), 32'd0);
      check("rst_awaddr", AWADDR, 32'd0);
      check("rst_araddr", ARADDR, 32'd0);
      check("rst_wdata", WDATA, 32'd0);
      check("rst_wstrb", 32'(WSTRB), 32'd0);
      check("rst_rdata", wb_dat_o, 32'd0);
      check("prot", {26'd0, AWPROT, ARPROT}, 32'd0);
      @(posedge ACLK); #1 ARESETN = 1'b1;
      @(negedge ACLK); check("idle_ctrl", ctrl_bits(), 32'd0);
      @(posedge ACLK); #1;

      // Zero-wait write: 3-cycle latency.
      fork
         wb_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, '0, 1'b0, 3);
         slave_wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00);
      join
      wb_idle();

      // W handshakes 3 cycles before AW: WVALID drops first, AWVALID held.
      fork
         wb_req(1'b1, 32'h14, 32'hCAFEF00D, 4'h3, 1'b0, '0, 1'b0, 6);
         slave_wr(32'h14, 32'hCAFEF00D, 4'h3, 3, 0, 0, 2'b00);
      join
      wb_idle();

      // Read with 2 AR wait cycles and 2 R wait cycles.
      fork
         wb_req(1'b0, 32'h20, '0, 4'hF, 1'b0, 32'h12345678, 1'b1, 7);
         slave_rd(32'h20, 2, 2, 32'h12345678, 2'b00);
      join
      wb_idle();

      // SLVERR on read and DECERR on write become wb_err_o.
      fork
         wb_req(1'b0, 32'h24, '0, 4'hF, 1'b1, '0, 1'b0, 3);
         slave_rd(32'h24, 0, 0, 32'h0BADF00D, 2'b10);
      join
      wb_idle();
      fork
         wb_req(1'b1, 32'h28, 32'h00000001, 4'h1, 1'b1, '0, 1'b0, 3);
         slave_wr(32'h28, 32'h00000001, 4'h1, 0, 0, 0, 2'b11);
      join
      wb_idle();

      // Initiator abandons the cycle in WR_RESP: B still completes, no ack.
      wb_we_i = 1'b1; wb_adr_i = 32'h2C; wb_dat_i = 32'h0000BEEF; wb_sel_i = 4'hC;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      fork
         begin
            int k = 0;
            @(negedge ACLK);
            while (!BREADY && k < 200) begin @(negedge ACLK); k++; end
            check("drop_bready_seen", 32'(BREADY), 32'd1);
            wb_idle();
         end
         slave_wr(32'h2C, 32'h0000BEEF, 4'hC, 0, 0, 3, 2'b00);
      join
      repeat (3) @(posedge ACLK);
      #1;
      fork
         wb_req(1'b0, 32'h30, '0, 4'hF, 1'b0, 32'hA5A50F0F, 1'b1, 3);
         slave_rd(32'h30, 0, 0, 32'hA5A50F0F, 2'b00);
      join
      wb_idle();

      // Back-to-back write then read (EXOKAY is a success).
      fork
         begin
            wb_req(1'b1, 32'h40, 32'h11223344, 4'hF, 1'b0, '0, 1'b0, 3);
            wb_req(1'b0, 32'h44, '0, 4'hF, 1'b0, 32'h55667788, 1'b1, 3);
         end
         begin
            slave_wr(32'h40, 32'h11223344, 4'hF, 0, 0, 0, 2'b00);
            slave_rd(32'h44, 0, 0, 32'h55667788, 2'b01);
         end
      join
      wb_idle();

`ifdef WB2AXI_TIMEOUT_EN
      // Slave never accepts AR: watchdog drops ARVALID and reports err.
      wb_req(1'b0, 32'h60, '0, 4'hF, 1'b1, '0, 1'b0, 17);
      check("timeout_arvalid", 32'(ARVALID), 32'd0);
      wb_idle();
      @(posedge ACLK); #1;
`endif

      // Asynchronous reset in the middle of a write.
      wb_we_i = 1'b1; wb_adr_i = 32'h50; wb_dat_i = 32'hFFFF0000; wb_sel_i = 4'hF;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      n = 0;
      @(negedge ACLK);
      while (!AWVALID && n < 200) begin @(negedge ACLK); n++; end
      check("midrst_pre_awvalid", 32'(AWVALID), 32'd1);
      #2 ARESETN = 1'b0;
      #1;
      check("midrst_ctrl", ctrl_bits(), 32'd0);
      check("midrst_awaddr", AWADDR, 32'd0);
      check("midrst_wdata", WDATA, 32'd0);
      check("midrst_wstrb", 32'(WSTRB), 32'd0);
      wb_idle();
      @(posedge ACLK); #1 ARESETN = 1'b1;
      repeat (2) @(posedge ACLK);

      @(negedge ACLK);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/wishbone_to_axi4lite.md
# wishbone_to_axi4lite

Bridge from a Wishbone classic slave port to an AXI4-Lite master port: the mirror of the team's AXI4-Lite-to-Wishbone bridge. It lets Wishbone-side initiators (controller, debug logic) reach AXI4-Lite peripherals. It handles one outstanding transfer at a time: it latches the Wishbone request, runs the AXI handshakes, and returns ack or err with read data.

## Interface
- ADDR_WIDTH, 32: address width on both sides.
- DATA_WIDTH, 32: data width; byte lanes = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024: watchdog limit; used only with WB2AXI_TIMEOUT_EN.
- ACLK  input  1  clock; all logic on rising edge.
- ARESETN  input  1  reset, asynchronous, active-low.
- wb_adr_i  input  ADDR_WIDTH  Wishbone address.
- wb_dat_i  input  DATA_WIDTH  write data.
- wb_sel_i  input  DATA_WIDTH/8  byte selects.
- wb_we_i  input  1  1 = write.
- wb_cyc_i  input  1  bus cycle active.
- wb_stb_i  input  1  strobe.
- wb_dat_o  output  DATA_WIDTH  read data, valid with wb_ack_o.
- wb_ack_o  output  1  one-cycle completion pulse.
- wb_err_o  output  1  one-cycle error pulse; mutually exclusive with ack.
- AWADDR / AWPROT  output  ADDR_WIDTH / 3  write address; AWPROT tied 3'b000.
- AWVALID / AWREADY  output / input  1  write-address handshake.
- WDATA / WSTRB  output  DATA_WIDTH / DATA_WIDTH/8  write data, strobes = latched wb_sel_i.
- WVALID / WREADY  output / input  1  write-data handshake.
- BRESP  input  2  write response.
- BVALID / BREADY  input / output  1  write-response handshake.
- ARADDR / ARPROT  output  ADDR_WIDTH / 3  read address; ARPROT tied 3'b000.
- ARVALID / ARREADY  output / input  1  read-address handshake.
- RDATA / RRESP  input  DATA_WIDTH / 2  read data and response.
- RVALID / RREADY  input / output  1  read-data handshake.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE: on wb_cyc_i & wb_stb_i, latch address, data, sel and we. A write enters WR_REQ with AWVALID = WVALID = 1. A read enters RD_REQ with ARVALID = 1.
- WR_REQ: AW and W complete independently. Each VALID drops on its own handshake, and flags aw_done / w_done record completion. When both are done, enter WR_RESP with BREADY = 1. A simultaneous AW and W handshake in the same cycle is legal.
- WR_RESP: on BVALID, drop BREADY and pulse wb_ack_o, or wb_err_o if BRESP[1] = 1 (SLVERR/DECERR). Return to IDLE.
- RD_REQ: on ARREADY, drop ARVALID and enter RD_RESP with RREADY = 1.
- RD_RESP: on RVALID, register RDATA into wb_dat_o and pulse ack or err (RRESP[1]). Return to IDLE.
- VALID is never withdrawn before its handshake. Latched AXI address and data are stable while VALID = 1.
- wb_cyc_i deasserted mid-transfer: the AXI transaction still completes, and the ack/err pulse is suppressed.
- A request still present in IDLE the cycle after an ack starts a new transfer (back-to-back allowed).

## Timing
- Reset values:
  - all AXI VALID/READY outputs 0;
  - AWADDR, ARADDR, WDATA, WSTRB 0;
  - wb_ack_o, wb_err_o 0; wb_dat_o 0;
  - state IDLE.
- Zero-wait AXI slave, stb sampled at edge 0:
  - AWVALID/WVALID or ARVALID high after edge 1;
  - handshake at edge 2;
  - response handshake at edge 3;
  - wb_ack_o high in the cycle after edge 3, i.e. a 3-cycle minimum latency.
- ack/err is high for exactly one cycle.
- Every AXI wait state adds one cycle.

## Configuration
- WB2AXI_TIMEOUT_EN defined:
  - A counter clears on leaving IDLE and increments in every non-IDLE state.
  - When it reaches TIMEOUT_CYCLES, all VALID/READY outputs drop, wb_err_o pulses, and the FSM returns to IDLE.
  - This is fault recovery only; the AXI slave must then be reset.
- WB2AXI_TIMEOUT_EN undefined: the bridge waits indefinitely, and no counter logic exists.

## Structure
- Package wb2axi_pkg holds:
  - state_t;
  - RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
- Sub-module wb2axi_watchdog holds the timeout counter and is instantiated only under WB2AXI_TIMEOUT_EN.

## Test plan
- Write 0x10 = 0xDEADBEEF, sel 4'hF, zero-wait slave, BRESP 00 -> AWADDR 0x10, WDATA 0xDEADBEEF, WSTRB F; wb_ack_o one cycle, 3 cycles after stb.
- Write where WREADY leads AWREADY by 3 cycles -> WVALID drops first, AWVALID held; exactly one ack after BVALID.
- Read 0x20, slave RDATA 0x12345678 after 2 wait cycles, RRESP 00 -> wb_dat_o 0x12345678 with ack, ARVALID held through wait.
- Read with RRESP 2'b10 -> wb_err_o pulse, wb_ack_o stays 0.
- wb_cyc_i dropped while in WR_RESP -> BREADY still completes B handshake; no ack/err; next request accepted.
- With WB2AXI_TIMEOUT_EN and TIMEOUT_CYCLES 16, slave never asserts ARREADY -> ARVALID drops and wb_err_o pulses at cycle 16; ARESETN low mid-write returns all outputs to reset values immediately.
